// File: rtl/store_buffer.sv
// Store buffer: DEPTH-entry FIFO between store_modifier and the data-memory write port.
// Word-crossing stores become two beats only when STORE_SPLIT_EN is defined; otherwise they are truncated and flagged.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_addr,
    input  logic [31:0]   in_wdata,
    input  logic [3:0]    in_be,
    input  logic          in_sb,
    input  logic          in_sh,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [31:0]   mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    output logic          sb_empty,
    output logic [CW-1:0] sb_count,
    output logic          misalign_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT1 = 2'd1;
    localparam logic [1:0] ST_BEAT2 = 2'd2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [29:0]   fifo_addr_q  [DEPTH];
    logic [31:0]   fifo_wdata_q [DEPTH];
    logic [3:0]    fifo_be1_q   [DEPTH];
    logic [3:0]    fifo_be2_q   [DEPTH];
    logic          fifo_split_q [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          misalign_q, misalign_d;

    logic          push, pop, load;
    logic [3:0]    be2_raw, in_be2;
    logic          would_split, in_split;
    logic [29:0]   head_addr;
    logic [31:0]   head_wdata;
    logic [3:0]    head_be1;

    // Second-beat lanes are the bytes that spill past the word boundary.
    function automatic logic [3:0] split_be2(input logic [1:0] off, input logic sb, input logic sh);
        logic [3:0] be2;
        be2 = 4'b0000;
        if (!sb && !sh) begin
            case (off)
                2'd1:    be2 = 4'b0001;
                2'd2:    be2 = 4'b0011;
                2'd3:    be2 = 4'b0111;
                default: be2 = 4'b0000;
            endcase
        end else if (sh && off == 2'd3) begin
            be2 = 4'b0001;
        end
        return be2;
    endfunction

    always_comb begin
        be2_raw     = split_be2(in_addr[1:0], in_sb, in_sh);
        would_split = |be2_raw;
`ifdef STORE_SPLIT_EN
        in_split = would_split;
        in_be2   = be2_raw;
`else
        in_split = 1'b0;
        in_be2   = 4'b0000;
`endif
    end

    always_comb begin
        push        = in_valid && in_ready;
        pop         = 1'b0;
        load        = 1'b0;
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
`ifdef STORE_SPLIT_EN
        misalign_d  = 1'b0;
`else
        misalign_d  = push && would_split;
`endif
        case (state_q)
            ST_IDLE: begin
                if (push || count_q != '0) begin
                    state_d = ST_BEAT1;
                    load    = 1'b1;
                end
            end
            ST_BEAT1: begin
                if (mem_gnt) begin
                    if (fifo_split_q[rd_ptr_q]) begin
                        state_d    = ST_BEAT2;
                        mem_addr_d = mem_addr_q + 32'd4;
                        mem_be_d   = fifo_be2_q[rd_ptr_q];
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ST_BEAT2: begin
                if (mem_gnt) pop = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (pop) begin
            if (count_d != '0) begin
                state_d = ST_BEAT1;
                load    = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
        // The next head may be the entry being written on this very edge.
        if (push && rd_ptr_d == wr_ptr_q) begin
            head_addr  = in_addr[31:2];
            head_wdata = in_wdata;
            head_be1   = in_be;
        end else begin
            head_addr  = fifo_addr_q[rd_ptr_d];
            head_wdata = fifo_wdata_q[rd_ptr_d];
            head_be1   = fifo_be1_q[rd_ptr_d];
        end
        if (load) begin
            mem_addr_d  = {head_addr, 2'b00};
            mem_be_d    = head_be1;
            mem_wdata_d = head_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= in_addr[31:2];
            fifo_wdata_q[wr_ptr_q] <= in_wdata;
            fifo_be1_q[wr_ptr_q]   <= in_be;
            fifo_be2_q[wr_ptr_q]   <= in_be2;
            fifo_split_q[wr_ptr_q] <= in_split;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            misalign_q  <= misalign_d;
        end
    end

    assign in_ready     = !rst && (count_q != FULL_CNT);
    assign mem_req      = (state_q != ST_IDLE);
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign sb_count     = count_q;
    assign sb_empty     = (count_q == '0) && (state_q == ST_IDLE);
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected beats are queued at issue, a negedge monitor checks every granted beat.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [3:0]  in_be = '0;
    logic        in_sb = 1'b0;
    logic        in_sh = 1'b0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        sb_empty;
    logic [2:0]  sb_count;
    logic        misalign_err;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_be(in_be),
        .in_sb(in_sb), .in_sh(in_sh),
        .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .sb_empty(sb_empty), .sb_count(sb_count), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

`ifdef STORE_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] a, input logic [3:0] b, input logic [31:0] w);
        beat_t e;
        e.addr = a; e.be = b; e.wdata = w;
        exp_q.push_back(e);
    endtask

    // Monitor: granted beats against the scoreboard, plus hold-stability while ungranted.
    logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_rst = 1'b1;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [3:0]  prev_be = '0;
    always @(negedge clk) begin
        if (!rst && mem_req && mem_gnt) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got addr %h be %h wdata %h, expected no beat", mem_addr, mem_be, mem_wdata);
            end else begin
                check("beat", {mem_addr, mem_be, mem_wdata}, exp_q.pop_front());
            end
        end
        if (!rst && !prev_rst && prev_req && !prev_gnt)
            check("hold", {mem_req, mem_addr, mem_be, mem_wdata}, {1'b1, prev_addr, prev_be, prev_wdata});
        prev_req   <= mem_req;
        prev_gnt   <= mem_gnt;
        prev_rst   <= rst;
        prev_addr  <= mem_addr;
        prev_be    <= mem_be;
        prev_wdata <= mem_wdata;
    end

    task automatic push_req(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b,
                            input logic sb, input logic sh);
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_addr = a; in_wdata = w; in_be = b; in_sb = sb; in_sh = sh;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("push_timeout", {71'd0, done}, 72'd1);
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (sb_empty && !mem_req) done = 1'b1;
        end
        check("drain_timeout", {71'd0, done}, 72'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_rst", {71'd0, in_ready}, 72'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req", {71'd0, mem_req}, 72'd0);
        check("rst_fields", {mem_addr, mem_be, mem_wdata}, 72'd0);
        check("rst_misalign", {71'd0, misalign_err}, 72'd0);
        check("rst_empty", {71'd0, sb_empty}, 72'd1);
        check("rst_count", {69'd0, sb_count}, 72'd0);
        check("rst_ready", {71'd0, in_ready}, 72'd1);
        @(posedge clk);
        #1;

        // Aligned word store, grant tied high
        mem_gnt = 1'b1;
        expect_beat(32'h100, 4'b1111, 32'hDEADBEEF);
        push_req(32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        check("sw_req_latency", {71'd0, mem_req}, 72'd1);
        check("sw_count", {69'd0, sb_count}, 72'd1);
        @(negedge clk);
        check("sw_empty_after", {70'd0, sb_empty, mem_req}, 72'b10);
        @(posedge clk);
        #1;

        // Word store crossing the boundary at offset 3
        expect_beat(32'h200, 4'b1000, 32'h44112233);
        if (SPLIT) expect_beat(32'h204, 4'b0111, 32'h44112233);
        push_req(32'h203, 32'h44112233, 4'b1000, 1'b0, 1'b0);
        @(negedge clk);
        check("misalign_pulse", {71'd0, misalign_err}, {71'd0, !SPLIT});
        @(negedge clk);
        check("misalign_end", {71'd0, misalign_err}, 72'd0);
        @(posedge clk);
        #1;
        wait_empty();
        check("split_count", {69'd0, sb_count}, 72'd0);

        // Fill to DEPTH with no grant, fifth request held
        mem_gnt = 1'b0;
        expect_beat(32'h1000, 4'b1111, 32'h11111111);
        push_req(32'h1000, 32'h11111111, 4'b1111, 1'b0, 1'b0);
        expect_beat(32'h1004, 4'b1111, 32'h22222222);
        push_req(32'h1004, 32'h22222222, 4'b1111, 1'b0, 1'b0);
        expect_beat(32'h1008, 4'b0011, 32'h33333333);
        push_req(32'h1008, 32'h33333333, 4'b0011, 1'b0, 1'b1);
        expect_beat(32'h100C, 4'b0001, 32'h44444444);
        push_req(32'h100C, 32'h44444444, 4'b0001, 1'b1, 1'b0);
        @(negedge clk);
        check("full_count", {69'd0, sb_count}, 72'd4);
        check("full_ready", {71'd0, in_ready}, 72'd0);
        @(posedge clk);
        #1;
        expect_beat(32'h1010, 4'b1111, 32'h55555555);
        in_valid = 1'b1; in_addr = 32'h1010; in_wdata = 32'h55555555; in_be = 4'b1111;
        in_sb = 1'b0; in_sh = 1'b0;
        @(negedge clk);
        check("held_ready", {71'd0, in_ready}, 72'd0);
        @(posedge clk);
        #1 mem_gnt = 1'b1;
        @(negedge clk);
        check("held_ready_gnt", {68'd0, in_ready, sb_count}, 72'd4);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_pop", {68'd0, in_ready, sb_count}, {68'd0, 1'b1, 3'd3});
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_empty();

        // Halfword at 0xFFFFFFFF with toggling grant
        mem_gnt = 1'b0;
        expect_beat(32'hFFFFFFFC, 4'b1000, 32'hCD0000AB);
        if (SPLIT) expect_beat(32'h00000000, 4'b0001, 32'hCD0000AB);
        push_req(32'hFFFFFFFF, 32'hCD0000AB, 4'b1000, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 mem_gnt = ~mem_gnt;
        end
        mem_gnt = 1'b1;
        wait_empty();

        // Reset while a split store is mid-flight with entries queued
        mem_gnt = 1'b0;
        expect_beat(32'h300, 4'b1000, 32'h88556677);
        push_req(32'h303, 32'h88556677, 4'b1000, 1'b0, 1'b0);
        push_req(32'h400, 32'hAAAA0000, 4'b1111, 1'b0, 1'b0);
        push_req(32'h500, 32'hBBBB0000, 4'b1111, 1'b0, 1'b0);
        @(posedge clk);
        #1 mem_gnt = 1'b1;
        @(posedge clk);
        #1 mem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_count", {69'd0, sb_count}, SPLIT ? 72'd3 : 72'd2);
        check("pre_rst_ready", {71'd0, in_ready}, 72'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_state", {68'd0, mem_req, sb_count}, 72'd0);
        check("post_rst_empty", {71'd0, sb_empty}, 72'd1);
        check("post_rst_addr", {40'd0, mem_addr}, 72'd0);
        @(posedge clk);
        #1 mem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", {71'd0, mem_req}, 72'd0);
        end
        check("scoreboard_left", exp_q.size(), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Buffers aligned store beats and issues them to the data memory write port.
- Sits directly downstream of store_modifier: takes its rotated write data and byte enables together with the original address and size flags.
- Decouples the core's MEM stage from memory wait states using a DEPTH-entry FIFO.
- Splits a store that crosses a word boundary into two word-aligned memory beats.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  store request valid.
- in_ready  out  1  buffer can accept a request this cycle.
- in_addr  in  32  byte address of the store, unrotated.
- in_wdata  in  32  lane-rotated write data from store_modifier.
- in_be  in  4  first-beat byte enables from store_modifier.
- in_sb  in  1  byte store.
- in_sh  in  1  halfword store.
- mem_req  out  1  write request to data memory.
- mem_gnt  in  1  memory accepts the current beat.
- mem_addr  out  32  word-aligned beat address.
- mem_be  out  4  beat byte enables.
- mem_wdata  out  32  beat write data.
- sb_empty  out  1  FIFO empty and no beat in flight (used by fence/load ordering).
- sb_count  out  CW  number of occupied entries.
- misalign_err  out  1  one-cycle pulse when a split is suppressed (see Optional Feature).

Behaviour:
- Reset:
  - The FIFO is cleared, the state goes to IDLE, and sb_count becomes 0.
  - mem_req, mem_addr, mem_be, mem_wdata and misalign_err are driven to 0; sb_empty is 1.
  - in_ready is 0 while rst is high and 1 in the first cycle after it.
  - Reset mid-operation discards all entries, including a beat already presented. mem_req is low after the edge that samples rst.
- Push:
  - A push occurs when in_valid && in_ready.
  - in_ready = (sb_count != DEPTH), taken from the registered count only. There is no same-cycle bypass when full.
  - Each entry stores: addr, wdata, be1 = in_be, split flag, be2.
- Split rule (off = in_addr[1:0]):
  - sw (!sb && !sh) with off != 0: split = 1, be2 = 0001 / 0011 / 0111 for off = 1 / 2 / 3.
  - sh with off == 3: split = 1, be2 = 0001.
  - All other cases: split = 0, be2 = 0000.
  - Both beats use the same wdata; rotation already places the bytes in the correct lanes.
- State machine (IDLE, BEAT1, BEAT2):
  - IDLE -> BEAT1 when sb_count != 0. An entry pushed at edge N is presented from cycle N+1.
  - BEAT1 outputs: mem_req = 1, mem_addr = {addr[31:2], 2'b00}, mem_be = be1.
  - BEAT1 on mem_gnt: if split, go to BEAT2; otherwise pop the head, then stay in BEAT1 if entries remain, else go to IDLE.
  - BEAT2 outputs: mem_req = 1, mem_addr = {addr[31:2], 2'b00} + 4 (0xFFFFFFFC wraps to 0x00000000), mem_be = be2.
  - BEAT2 on mem_gnt: pop the head, then go to BEAT1 or IDLE as above.
  - In IDLE: mem_req = 0, and mem_addr/mem_be/mem_wdata hold their last values.
- Handshake:
  - Once raised, mem_req and its beat fields are held stable until mem_gnt; the request is never retracted.
  - Each beat completes on exactly one granted cycle. Back-to-back grants give one beat per cycle.
- Simultaneous push and pop: sb_count is unchanged, and both the entry write and the head advance take effect.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- sb_empty = (sb_count == 0) && (state == IDLE).
- The stored entry wdata is never altered.

Optional Feature:
- Macro: STORE_SPLIT_EN.
- Defined: splitting is performed as described in Behaviour; misalign_err is tied to 0.
- Undefined:
  - split is forced to 0, so only the first beat (be1) is written and the crossing bytes are dropped.
  - misalign_err pulses high for one cycle, on the cycle after the push of any entry that would have split.
  - The state machine never enters BEAT2.

Test Plan:
- Reset, then sw addr 0x100 data 0xDEADBEEF be 1111 with mem_gnt tied high -> mem_req in cycle 1 after the push; addr 0x100, be 1111, wdata 0xDEADBEEF; sb_empty back to 1 in the following cycle.
- sw addr 0x203 wdata 0x44112233 (rotated) be 1000, STORE_SPLIT_EN defined -> beat 0x200 be 1000, then beat 0x204 be 0111, same wdata, one entry popped.
- Same stimulus with STORE_SPLIT_EN undefined -> single beat 0x200 be 1000; misalign_err is a single one-cycle pulse.
- DEPTH = 4, mem_gnt = 0, push 5 requests -> in_ready low after the 4th; sb_count = 4; the 5th is held. Then raise mem_gnt -> beats issued in FIFO order, and the 5th is accepted the cycle after the first pop.
- mem_gnt toggling 0/1 every cycle during a split sh at 0xFFFFFFFF -> mem_addr, mem_be and mem_wdata stable while ungranted; second beat addr 0x00000000 be 0001.
- Assert rst while in BEAT2 with 3 entries queued -> next cycle: mem_req = 0, sb_count = 0, sb_empty = 1, no further beats issued.
